// File: rtl/pulse_gen_pkg.sv
// Shared defaults and FSM state encoding for the coincidence-trigger test pulse generator.
package pulse_gen_pkg;

  localparam int CH_DEF    = 6;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: registered output, high while the run timer is in [delay+1, delay+width].
// Compares against the timer value the top is about to load, so the pulse lands with zero extra latency.
module pulse_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run_nx,
  input  logic             en,
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W:0]   cnt_nx,
  output logic             out
);

  logic [CNT_W:0] lo;
  logic [CNT_W:0] hi;
  logic           on;

  // One extra bit keeps delay+width from wrapping at the top of the range.
  always_comb begin
    lo = {1'b0, delay} + (CNT_W+1)'(1);
    hi = {1'b0, delay} + {1'b0, width};
    on = run_nx && en && (width != '0) && (cnt_nx >= lo) && (cnt_nx <= hi);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) out <= 1'b0;
    else       out <= on;
  end

endmodule

// File: rtl/test_pulse_gen6.sv
// Test pulse generator: on an accepted start, drives CH delayed, equal-width pulses into the trigger.
// All outputs registered; a start outside IDLE is dropped, never queued.
module test_pulse_gen6
  import pulse_gen_pkg::*;
#(
  parameter int CH    = CH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [CH-1:0]       mask,
  input  logic [CH*CNT_W-1:0] delay_cfg,
  input  logic [CNT_W-1:0]    width_cfg,
  output logic [CH-1:0]       out,
  output logic                busy,
  output logic                done
);

  state_t              state;
  state_t              state_nx;
  logic [CNT_W:0]      cnt;
  logic [CNT_W:0]      cnt_nx;
  logic [CNT_W:0]      end_eff;
  logic [CNT_W:0]      span;
  logic [CH-1:0]       mask_q;
  logic [CH-1:0]       mask_eff;
  logic [CH*CNT_W-1:0] delay_q;
  logic [CH*CNT_W-1:0] delay_eff;
  logic [CNT_W-1:0]    width_q;
  logic [CNT_W-1:0]    width_eff;
  logic                accept;
  logic                run_nx;
  logic                busy_nx;
  logic                done_nx;

  assign accept = (state == IDLE) && start;

  // In IDLE the live inputs are used so the first pulse cycle can follow the accepting edge directly.
  always_comb begin
    mask_eff  = (state == IDLE) ? mask      : mask_q;
    delay_eff = (state == IDLE) ? delay_cfg : delay_q;
    width_eff = (state == IDLE) ? width_cfg : width_q;
  end

  always_comb begin
    end_eff = '0;
    span    = '0;
    for (int i = 0; i < CH; i++) begin
      span = {1'b0, delay_eff[i*CNT_W +: CNT_W]} + {1'b0, width_eff};
      if (mask_eff[i] && (width_eff != '0) && (span > end_eff)) end_eff = span;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // An empty run (END=0) skips RUN so done follows the accepting edge with busy never raised.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nx   = (CNT_W+1)'(1);
          state_nx = (end_eff == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == end_eff) begin
          state_nx = DONE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + (CNT_W+1)'(1);
        end
      end
      DONE: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_comb begin
    busy_nx = (state_nx == RUN);
    done_nx = (state_nx == DONE);
    run_nx  = busy_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busy_nx;
      done <= done_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q  <= '0;
      delay_q <= '0;
      width_q <= '0;
    end else if (accept) begin
      mask_q  <= mask;
      delay_q <= delay_cfg;
      width_q <= width_cfg;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_chan
    pulse_chan #(.CNT_W(CNT_W)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .run_nx (run_nx),
      .en     (mask_eff[g]),
      .delay  (delay_eff[g*CNT_W +: CNT_W]),
      .width  (width_eff),
      .cnt_nx (cnt_nx),
      .out    (out[g])
    );
  end

endmodule

// File: tb/tb_test_pulse_gen6.sv
// Scoreboard bench: each accepted run queues its expected profile; a negedge monitor checks every cycle.
module tb_test_pulse_gen6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  mask = '0;
  logic [47:0] delay_cfg = '0;
  logic [7:0]  width_cfg = '0;
  logic [5:0]  out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int and_cnt = 0;

  typedef struct {
    int          k;
    logic [5:0]  mask;
    logic [47:0] dly;
    int          w;
    int          endv;
    int          and_exp;
  } rec_t;

  rec_t q[$];

  test_pulse_gen6 dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mask      (mask),
    .delay_cfg (delay_cfg),
    .width_cfg (width_cfg),
    .out       (out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Expected pulse profile of the run at the queue head, offset o = cycles since the accepting edge.
  always @(negedge clk) begin
    logic [5:0] eo;
    logic       eb;
    logic       ed;
    int         o;
    int         d;
    eo = '0;
    eb = 1'b0;
    ed = 1'b0;
    if (q.size() > 0) begin
      o = cyc - q[0].k + 1;
      if (o >= 1) begin
        for (int i = 0; i < 6; i++) begin
          d = int'(q[0].dly[i*8 +: 8]);
          if (q[0].mask[i] && q[0].w > 0 && o >= d + 1 && o <= d + q[0].w) eo[i] = 1'b1;
        end
        eb = (o <= q[0].endv);
        ed = (o == q[0].endv + 1);
      end
    end
    chk("out", 32'(out), 32'(eo));
    chk("busy", 32'(busy), 32'(eb));
    chk("done", 32'(done), 32'(ed));
    if (q.size() == 0) and_cnt = 0;
    else if (&out) and_cnt++;
    if (ed) begin
      chk("and_cycles", 32'(and_cnt), 32'(q[0].and_exp));
      and_cnt = 0;
      void'(q.pop_front());
    end
  end

  function automatic logic [47:0] dl(input int d0, input int d1, input int d2,
                                     input int d3, input int d4, input int d5);
    logic [47:0] r;
    r[7:0]   = d0[7:0];
    r[15:8]  = d1[7:0];
    r[23:16] = d2[7:0];
    r[31:24] = d3[7:0];
    r[39:32] = d4[7:0];
    r[47:40] = d5[7:0];
    return r;
  endfunction

  task automatic wait_idle();
    int g = 0;
    while (q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: %0d runs still pending", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Issues one start; afterwards the inputs are scrambled, which must not disturb the latched run.
  task automatic run(input logic [5:0] m, input logic [47:0] d, input int w,
                     input int endv, input int and_exp);
    wait_idle();
    mask      = m;
    delay_cfg = d;
    width_cfg = w[7:0];
    start     = 1'b1;
    @(posedge clk);
    #1;
    q.push_back('{cyc, m, d, w, endv, and_exp});
    start     = 1'b0;
    mask      = ~m;
    delay_cfg = ~d;
    width_cfg = 8'hAA;
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run(6'h3F, dl(2, 2, 2, 2, 2, 2), 3, 5, 3);
    run(6'h3F, dl(0, 1, 2, 3, 4, 5), 2, 7, 0);
    run(6'h00, dl(4, 4, 4, 4, 4, 4), 5, 0, 0);
    run(6'h3F, dl(1, 2, 3, 4, 5, 6), 0, 0, 0);
    run(6'h08, dl(0, 0, 0, 255, 0, 0), 255, 510, 0);
    run(6'h05, dl(3, 20, 7, 0, 0, 0), 4, 11, 0);

    // Start held high: each run is 2 RUN cycles, then DONE (start ignored), then IDLE, then re-accept.
    wait_idle();
    mask      = 6'h3F;
    delay_cfg = dl(1, 1, 1, 1, 1, 1);
    width_cfg = 8'd1;
    start     = 1'b1;
    for (int r = 0; r < 3; r++) begin
      @(posedge clk);
      #1;
      q.push_back('{cyc, 6'h3F, dl(1, 1, 1, 1, 1, 1), 1, 2, 1});
      repeat (3) @(posedge clk);
    end
    #1 start = 1'b0;

    // Reset during cycle k+3 of a D=2, W=3 run, while all outputs are high.
    run(6'h3F, dl(2, 2, 2, 2, 2, 2), 3, 5, 3);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    q.delete();
    #1;
    chk("abort_out", 32'(out), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    run(6'h3F, dl(2, 2, 2, 2, 2, 2), 3, 5, 3);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
